quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Upstream stage for the 4-bit up/down counter. It converts two asynchronous quadrature encoder channels (A/B) into a one-cycle step pulse plus a direction level. Both are registered, so they drive the counter's enable and up/down inputs directly. The block synchronises, debounces and decodes the inputs, and flags illegal double transitions.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed before a channel change is accepted. Legal range 1..255.
- clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  reset, synchronous, active-high.
- enc_a  input  1  encoder channel A, asynchronous to clock.
- enc_b  input  1  encoder channel B, asynchronous to clock.
- step_en  output  1  one-cycle pulse per accepted legal transition; connects to the counter enable.
- step_up  output  1  direction of the latest step (1 = up, 0 = down); connects to the counter up/down input.
- illegal  output  1  one-cycle pulse when both filtered channels change in the same cycle.
- err_sticky  output  1  set by any illegal pulse; cleared only by reset.

## Operation
- **Synchroniser.** Each channel passes through a 2-flop synchroniser.
- **Debounce.** Each channel has its own filter.
  - The counter clears whenever the synced value equals the filtered value.
  - It increments while the two differ.
  - When the count reaches DEBOUNCE_CYCLES, the filtered value takes the synced value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- **State machine.** Two states, S_INIT and S_RUN.
  - Reset enters S_INIT.
  - In S_INIT, the filtered values and prev_ab load directly from the synced values every cycle. No step or illegal output is produced.
  - After INIT_CYCLES = 3 cycles, S_INIT moves to S_RUN. This prevents a spurious step when the encoder rests at a non-00 position at reset.
  - In S_RUN the decoder compares the filtered pair {a,b} with prev_ab every cycle.
- **Decode (S_RUN)**, using the Gray sequence 00→01→11→10→00:
  - new is the forward successor of prev_ab: step_en=1, step_up=1.
  - new is the backward successor: step_en=1, step_up=0.
  - both bits differ: illegal=1, err_sticky=1, no step, step_up unchanged.
  - no change: all pulses 0.
  - prev_ab updates to the new pair in every case, including illegal transitions, so decoding resynchronises.
- step_up holds its last value between pulses and never changes except together with step_en.

## Timing
- **Reset values.** step_en=0, step_up=0, illegal=0, err_sticky=0; sync flops, filtered values and prev_ab = 00; debounce counters = 0; state = S_INIT.
- **Latency.** Define edge N as the first rising edge at which sync flop 1 captures a new level that then stays stable.
  - The filtered value updates at edge N+1+DEBOUNCE_CYCLES.
  - step_en and step_up register at edge N+2+DEBOUNCE_CYCLES.
  - step_en stays high for exactly one cycle.
- **Glitch rejection.** A pulse shorter than DEBOUNCE_CYCLES synced cycles never reaches the filtered value and produces no output.
- **Throughput.** At most one step per cycle. Consecutive legal transitions on alternating channels each produce a pulse; minimum spacing is DEBOUNCE_CYCLES+1 cycles.
- **Simultaneous commit.** If both filters commit on the same edge, the transition is illegal even if the physical order was legal. This is the required behaviour.
- **Reset mid-operation.**
  - Reset asserted in any cycle overrides everything and applies the reset values on the next edge.
  - A step_en due that cycle is suppressed.
  - S_INIT then re-runs.

## Structure
- Package quad_pkg holds:
  - state enum {S_INIT, S_RUN}
  - INIT_CYCLES = 3
  - function gray_next(ab) returning the forward successor; backward is the inverse lookup.
- Sub-module input_debounce contains the synchroniser plus filter. It is parameterised by DEBOUNCE_CYCLES and instantiated once per channel.
- Top level holds the FSM, prev_ab, decode logic and output registers.

## Test plan
- **Reset with A=B=1.** Hold reset 2 cycles with enc_a=enc_b=1, release, wait 20 cycles.
  - No step_en and no illegal.
  - prev_ab = 11.
- **Four forward detents.** DEBOUNCE_CYCLES=4, run the sequence 00→01→11→10→00 with each level held 10 cycles.
  - Exactly 4 step_en pulses, all with step_up=1.
  - First pulse lands 6 cycles after the edge-N capture.
- **Reverse after forward.** Run 00→01, then 01→00.
  - Pulse 1 has step_up=1; pulse 2 has step_up=0.
  - step_up stays 0 afterwards.
- **Glitch rejection.** DEBOUNCE_CYCLES=4, pulse enc_a high for 3 cycles.
  - No step_en.
  - Debounce counter returns to 0.
- **Illegal transition.** Toggle enc_a and enc_b on the same clock, from 00 to 11.
  - One illegal pulse, err_sticky=1, no step_en.
  - A following legal 11→10 produces a step with step_up=1.
- **Reset during step.** Assert reset on the cycle before an expected step_en.
  - No pulse appears.
  - All outputs are 0 and err_sticky is cleared.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder: FSM states,
// start-up settle length and the forward Gray-code successor.
package quad_pkg;

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam int INIT_CYCLES = 3;

  // Forward rotation 00 -> 01 -> 11 -> 10 -> 00; the backward successor of x
  // is the y for which gray_next(y) == x.
  function automatic logic [1:0] gray_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One encoder channel: 2-flop synchroniser followed by a stable-count filter.
// While load is high the filter tracks the synced level directly.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic din,
  output logic synced,
  output logic filtered
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic [CW-1:0] cnt;

  // NOTE: every register in a clocked block uses <= so all flops sample
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b0;
      synced   <= 1'b0;
      filtered <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1  <= din;
      synced <= sync1;
      if (load) begin
        filtered <= synced;
        cnt      <= '0;
      end else if (synced == filtered) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
        filtered <= synced;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: debounced channels feed a Gray-sequence decoder
// that emits a registered step pulse, direction level and illegal flag.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  output logic step_en,
  output logic step_up,
  output logic illegal,
  output logic err_sticky
);

  localparam logic [1:0] INIT_LAST = 2'(INIT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] init_cnt;
  logic [1:0] prev_ab;
  logic [1:0] cur_ab;
  logic       sync_a, sync_b, filt_a, filt_b;
  logic       load;
  logic       step_nxt, up_nxt, ill_nxt;

  assign load   = (state == S_INIT);
  assign cur_ab = {filt_a, filt_b};

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clock(clock), .reset(reset), .load(load), .din(enc_a),
    .synced(sync_a), .filtered(filt_a)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clock(clock), .reset(reset), .load(load), .din(enc_b),
    .synced(sync_b), .filtered(filt_b)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through it leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    step_nxt  = 1'b0;
    up_nxt    = step_up;
    ill_nxt   = 1'b0;
    case (state)
      S_INIT: if (init_cnt == INIT_LAST) state_nxt = S_RUN;
      default: begin
        if (cur_ab == gray_next(prev_ab)) begin
          step_nxt = 1'b1;
          up_nxt   = 1'b1;
        end else if (prev_ab == gray_next(cur_ab)) begin
          step_nxt = 1'b1;
          up_nxt   = 1'b0;
        end else if (cur_ab == ~prev_ab) begin
          ill_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      prev_ab    <= 2'b00;
      step_en    <= 1'b0;
      step_up    <= 1'b0;
      illegal    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (load && init_cnt != INIT_LAST) ? init_cnt + 2'd1 : 2'd0;
      // Start-up seeds from the synchroniser so a resting non-00 encoder
      // does not look like a transition when decoding begins.
      prev_ab  <= load ? {sync_a, sync_b} : cur_ab;
      step_en  <= step_nxt;
      illegal  <= ill_nxt;
      if (step_nxt) step_up    <= up_nxt;
      if (ill_nxt)  err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench: directed scenarios plus random encoder moves, checked
// every cycle against an event-schedule model of the decoder.
module tb_quad_step_decoder;

  localparam int D = 4;

  typedef struct {
    int edge_no;
    bit en;
    bit up;
    bit ill;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;
  logic step_en, step_up, illegal, err_sticky;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_steps = 0;
  int   n_ill   = 0;
  ev_t  q[$];
  bit [1:0] m_ab  = 2'b00;
  bit       m_up  = 1'b0;
  bit       m_err = 1'b0;
  int       gray_seq[4] = '{0, 1, 3, 2};

  quad_step_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .step_en(step_en), .step_up(step_up), .illegal(illegal),
    .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pos_of(input bit [1:0] ab);
    for (int i = 0; i < 4; i++) if (gray_seq[i] == int'(ab)) return i;
    return 0;
  endfunction

  // Advance one clock, then compare every output with the model.
  task automatic tick();
    bit   e_en, e_ill;
    ev_t  ev;
    @(posedge clock);
    e_en  = 1'b0;
    e_ill = 1'b0;
    if (reset) begin
      q.delete();
      m_up  = 1'b0;
      m_err = 1'b0;
    end else if (q.size() > 0 && q[0].edge_no == cyc + 1) begin
      ev    = q.pop_front();
      e_en  = ev.en;
      e_ill = ev.ill;
      if (ev.en)  m_up  = ev.up;
      if (ev.ill) m_err = 1'b1;
    end
    #1;
    cyc++;
    if (step_en === 1'b1) n_steps++;
    if (illegal === 1'b1) n_ill++;
    check("step_en",    32'(step_en),    32'(e_en));
    check("step_up",    32'(step_up),    32'(m_up));
    check("illegal",    32'(illegal),    32'(e_ill));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive a new stable pair; schedule the expected decoder response.
  task automatic set_ab(input bit [1:0] nab);
    ev_t ev;
    int  po, pn;
    po = pos_of(m_ab);
    pn = pos_of(nab);
    ev.edge_no = cyc + 3 + D;
    ev.en  = 1'b0;
    ev.up  = 1'b0;
    ev.ill = 1'b0;
    if (nab == ~m_ab) ev.ill = 1'b1;
    else if (pn == (po + 1) % 4) begin ev.en = 1'b1; ev.up = 1'b1; end
    else if (pn == (po + 3) % 4) begin ev.en = 1'b1; ev.up = 1'b0; end
    if (ev.en || ev.ill) q.push_back(ev);
    m_ab  = nab;
    enc_a = nab[1];
    enc_b = nab[0];
  endtask

  task automatic glitch(input bit on_a, input int len);
    if (on_a) enc_a = ~m_ab[1]; else enc_b = ~m_ab[0];
    ticks(len);
    enc_a = m_ab[1];
    enc_b = m_ab[0];
  endtask

  task automatic apply_reset(input bit [1:0] ab);
    reset = 1'b1;
    enc_a = ab[1];
    enc_b = ab[0];
    m_ab  = ab;
    ticks(2);
    reset = 1'b0;
  endtask

  initial begin
    int s0, i0, c0, r, hold;
    bit found;

    // Reset with encoder resting at 11: no spurious step.
    apply_reset(2'b11);
    ticks(20);
    check("rst11_no_step", 32'(n_steps), 0);
    check("rst11_no_ill",  32'(n_ill), 0);
    check("rst11_prev_ab", 32'(dut.prev_ab), 32'h3);

    // Four forward detents from 00, with first-pulse latency.
    apply_reset(2'b00);
    ticks(20);
    s0 = n_steps;
    set_ab(2'b01);
    c0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (step_en === 1'b1) found = 1'b1;
    end
    check("fwd_first_found", 32'(found), 1);
    check("fwd_first_latency", 32'(cyc - c0), 32'(1 + 2 + D));
    ticks(3);
    set_ab(2'b11); ticks(10);
    set_ab(2'b10); ticks(10);
    set_ab(2'b00); ticks(10);
    check("fwd_count", 32'(n_steps - s0), 4);

    // Reverse after forward.
    set_ab(2'b01); ticks(10);
    check("rev_up1", 32'(step_up), 1);
    set_ab(2'b00); ticks(10);
    check("rev_up0", 32'(step_up), 0);
    ticks(10);
    check("rev_up_hold", 32'(step_up), 0);

    // Glitch shorter than the debounce window.
    s0 = n_steps;
    glitch(1'b1, 3);
    ticks(10);
    check("glitch_no_step", 32'(n_steps - s0), 0);
    check("glitch_cnt_zero", 32'(dut.u_deb_a.cnt), 0);

    // Illegal double transition, then a legal forward move.
    s0 = n_steps;
    i0 = n_ill;
    set_ab(2'b11); ticks(10);
    check("ill_count", 32'(n_ill - i0), 1);
    check("ill_no_step", 32'(n_steps - s0), 0);
    check("ill_sticky", 32'(err_sticky), 1);
    set_ab(2'b10); ticks(10);
    check("ill_then_step", 32'(n_steps - s0), 1);
    check("ill_then_up", 32'(step_up), 1);

    // Reset on the cycle before a due step.
    s0 = n_steps;
    set_ab(2'b00);
    c0 = cyc + 3 + D;
    while (cyc < c0 - 1) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_en",     32'(step_en), 0);
    check("rst_mid_up",     32'(step_up), 0);
    check("rst_mid_ill",    32'(illegal), 0);
    check("rst_mid_sticky", 32'(err_sticky), 0);
    tick();
    reset = 1'b0;
    ticks(20);
    check("rst_mid_no_step", 32'(n_steps - s0), 0);

    // Randomised encoder activity against the model.
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      hold = $urandom_range(D + 2, D + 6);
      if (r <= 2)      set_ab(2'(gray_seq[(pos_of(m_ab) + 1) % 4]));
      else if (r <= 5) set_ab(2'(gray_seq[(pos_of(m_ab) + 3) % 4]));
      else if (r == 6) set_ab(~m_ab);
      else if (r == 7) glitch(1'($urandom_range(0, 1)), $urandom_range(1, D - 1));
      ticks(hold);
    end
    ticks(D + 4);
    check("rand_queue_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
